// File: rtl/fir_mac_filter.sv
// fir_mac_filter: symmetric FIR low-pass using one time-multiplexed pre-add/multiply-accumulate unit,
// valid/ready sample input, run-time loadable coefficients, truncated and saturated unsigned output.
module fir_mac_filter #(
    parameter int DATA_W = 10,
    parameter int TAPS   = 31,
    parameter int COEF_W = 8,
    parameter int FRAC   = 10,
    parameter int OUT_W  = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_sample,
    input  logic                          coef_we,
    input  logic [$clog2((TAPS+1)/2)-1:0] coef_addr,
    input  logic [COEF_W-1:0]             coef_data,
    output logic                          out_valid,
    output logic [OUT_W-1:0]              out_sample,
    output logic                          out_sat
);
    localparam int NC    = (TAPS + 1) / 2;
    localparam int M     = NC - 1;
    localparam int KW    = $clog2(NC);
    localparam int XW    = $clog2(TAPS);
    localparam int PW    = DATA_W + 1 + COEF_W;
    localparam int ACC_W = PW + KW;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                        state_q, state_d;
    logic [TAPS-1:0][DATA_W-1:0]   x_q, x_d, x_base;
    logic [NC-1:0][COEF_W-1:0]     c_q, c_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [ACC_W-1:0]              acc_q, acc_d, r;
    logic [OUT_W-1:0]              out_sample_q, out_sample_d;
    logic                          out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic                          accept, last, sat;
    logic [XW-1:0]                 kx, mx;
    logic [DATA_W:0]               pre;
    logic [PW-1:0]                 prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (in_valid ? MAC : IDLE) :
                  (state_q == MAC)  ? (last ? DONE : MAC) : IDLE;
    end

    always_comb begin
        in_ready = state_q == IDLE;
        accept   = in_ready && in_valid;
    end

    always_comb begin
        kx   = XW'(k_q);
        mx   = XW'(TAPS - 1) - kx;
        last = k_q == KW'(M);
        // The centre tap has no mirror partner, so it bypasses the pre-adder.
        pre  = last ? {1'b0, x_q[kx]} : {1'b0, x_q[kx]} + {1'b0, x_q[mx]};
        prod = {{COEF_W{1'b0}}, pre} * {{(DATA_W + 1){1'b0}}, c_q[k_q]};
        k_d  = (state_q == MAC) ? k_q + KW'(1) : '0;
        acc_d = accept ? '0 : (state_q == MAC) ? acc_q + ACC_W'(prod) : acc_q;
        r    = acc_q >> FRAC;
        sat  = |(r >> OUT_W);
        out_valid_d  = state_q == DONE;
        out_sample_d = (state_q == DONE) ? (sat ? '1 : OUT_W'(r)) : out_sample_q;
        out_sat_d    = (state_q == DONE) ? sat : out_sat_q;
        // Clear lands first so a simultaneously accepted sample enters a zeroed line.
        x_base = (in_ready && clear) ? '0 : x_q;
        x_d    = accept ? {x_base[TAPS-2:0], in_sample} : x_base;
        c_d    = c_q;
        if (in_ready && coef_we && int'(coef_addr) <= M) c_d[coef_addr] = coef_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q          <= '0;
            c_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            out_sat_q    <= 1'b0;
        end else begin
            x_q          <= x_d;
            c_q          <= c_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign out_sat    = out_sat_q;
endmodule

// File: tb/tb_fir_mac_filter.sv
// tb_fir_mac_filter: random and directed stimulus for fir_mac_filter, checked against a
// direct-convolution reference model of the symmetric filter.
module tb_fir_mac_filter;
    localparam int DATA_W = 10;
    localparam int TAPS   = 31;
    localparam int COEF_W = 8;
    localparam int FRAC   = 10;
    localparam int OUT_W  = 10;
    localparam int NC     = (TAPS + 1) / 2;
    localparam int M      = NC - 1;
    localparam int KW     = $clog2(NC);

    logic              clk = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0, coef_we = 1'b0;
    logic [DATA_W-1:0] in_sample = '0;
    logic [KW-1:0]     coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              in_ready, out_valid, out_sat;
    logic [OUT_W-1:0]  out_sample;

    int n_chk = 0, n_fail = 0;
    int xm[TAPS];
    int cm[NC];

    fir_mac_filter #(
        .DATA_W(DATA_W), .TAPS(TAPS), .COEF_W(COEF_W), .FRAC(FRAC), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_sample(out_sample), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Full-length convolution with the mirrored coefficient set h[i] = c[min(i, TAPS-1-i)].
    function automatic void model_expect(output int y, output bit s);
        longint acc = 0;
        for (int i = 0; i < TAPS; i++)
            acc += longint'(cm[(i <= M) ? i : TAPS - 1 - i]) * longint'(xm[i]);
        acc = acc >>> FRAC;
        s = acc > longint'(2 ** OUT_W - 1);
        y = s ? 2 ** OUT_W - 1 : int'(acc);
    endfunction

    function automatic void model_accept(input int s, input bit clr);
        if (clr) foreach (xm[i]) xm[i] = 0;
        for (int i = TAPS - 1; i > 0; i--) xm[i] = xm[i - 1];
        xm[0] = s;
    endfunction

    task automatic write_coef(input int a, input int d);
        coef_we = 1'b1; coef_addr = KW'(a); coef_data = COEF_W'(d);
        step();
        coef_we = 1'b0;
        if (a <= M) cm[a] = d;
    endtask

    task automatic set_all(input int d);
        for (int a = 0; a <= M; a++) write_coef(a, d);
    endtask

    task automatic send(input int s, input bit clr, input bit stray, input string tag, output int got);
        int n, y;
        bit sat, ready_seen;
        in_valid = 1'b1; in_sample = DATA_W'(s); clear = clr;
        n = 0;
        while (!in_ready && n < 40) begin step(); n++; end
        step();
        in_valid = 1'b0; clear = 1'b0;
        model_accept(s, clr);
        model_expect(y, sat);
        if (stray) begin
            coef_we = 1'b1; coef_addr = KW'($urandom_range(M)); coef_data = 200; clear = 1'b1;
        end
        n = 0;
        ready_seen = 1'b0;
        while (!out_valid && n < 40) begin
            if (n == 4) begin coef_we = 1'b0; clear = 1'b0; end
            ready_seen |= in_ready;
            step();
            n++;
        end
        coef_we = 1'b0; clear = 1'b0;
        check({tag, "_ready_low"}, ready_seen, 0);
        check({tag, "_latency"}, n, 17);
        check({tag, "_out"}, out_sample, y);
        check({tag, "_sat"}, out_sat, sat);
        got = out_sample;
        step();
        check({tag, "_pulse"}, out_valid, 0);
    endtask

    initial begin
        int got, t, last_acc, acc_n, out_n, cur, y;
        bit sat, seen;
        int exp_q[$];
        bit sat_q[$];
        foreach (xm[i]) xm[i] = 0;
        foreach (cm[i]) cm[i] = 0;

        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_out_sat", out_sat, 0);
        reset = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1);

        begin
            int dflt[NC] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};
            for (int a = 0; a < NC; a++) write_coef(a, dflt[a]);
        end
        for (int i = 0; i < 31; i++) send(512, i == 0, 0, "dflt", got);
        check("dflt_steady", got, 514);
        check("dflt_steady_sat", out_sat, 0);

        set_all(0);
        write_coef(0, 64);
        for (int i = 0; i < 32; i++) begin
            send((i == 0) ? 1023 : 0, i == 0, 0, "imp", got);
            check("imp_const", got, (i == 0 || i == 30) ? 63 : 0);
        end

        set_all(255);
        for (int i = 0; i < 31; i++) send(1023, i == 0, 0, "satr", got);
        check("sat_const", got, 1023);
        check("sat_flag", out_sat, 1);
        set_all(0);
        send(1023, 0, 0, "unsat", got);
        check("unsat_const", got, 0);
        check("unsat_flag", out_sat, 0);

        for (int a = 0; a <= M; a++) write_coef(a, $urandom_range(255));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7) == 0) write_coef($urandom_range(M), $urandom_range(255));
            if ($urandom_range(9) == 0) begin
                clear = 1'b1; step(); clear = 1'b0;
                foreach (xm[j]) xm[j] = 0;
            end
            send($urandom_range(1023), $urandom_range(7) == 0, $urandom_range(1) == 1, "rnd", got);
        end

        in_valid = 1'b1; in_sample = DATA_W'($urandom_range(1023));
        t = 0; last_acc = 0; acc_n = 0; out_n = 0;
        while (out_n < 5 && t < 300) begin
            seen = in_valid && in_ready;
            cur = int'(in_sample);
            step();
            t++;
            if (seen) begin
                if (acc_n > 0) check("thru_gap", t - last_acc, 18);
                last_acc = t;
                acc_n++;
                model_accept(cur, 0);
                model_expect(y, sat);
                exp_q.push_back(y);
                sat_q.push_back(sat);
                in_sample = DATA_W'($urandom_range(1023));
                if (acc_n == 5) in_valid = 1'b0;
            end else if (in_valid) begin
                check("thru_ready_low", in_ready, out_valid ? 1 : 0);
            end
            if (out_valid) begin
                check("thru_latency", t - last_acc, 17);
                if (exp_q.size() > 0) begin
                    check("thru_out", out_sample, exp_q.pop_front());
                    check("thru_sat", out_sat, sat_q.pop_front());
                end
                out_n++;
            end
        end
        in_valid = 1'b0;
        check("thru_outputs", out_n, 5);
        check("thru_accepts", acc_n, 5);
        step();

        set_all(0);
        write_coef(0, 255);
        send(100, 1, 0, "pre_rst", got);
        check("pre_rst_const", got, 24);
        in_valid = 1'b1; in_sample = 77;
        step();
        in_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        check("midrst_out_sample", out_sample, 0);
        check("midrst_out_valid", out_valid, 0);
        step();
        reset = 1'b0;
        foreach (xm[i]) xm[i] = 0;
        foreach (cm[i]) cm[i] = 0;
        seen = 1'b0;
        repeat (25) begin seen |= out_valid; step(); end
        check("midrst_no_valid", seen, 0);
        check("midrst_ready", in_ready, 1);
        write_coef(0, 255);
        send(100, 1, 0, "post_rst", got);
        check("post_rst_const", got, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
